// File: rtl/sys_seg_scan.sv
// sys_seg_scan: 8-digit multiplexed 7-segment display driver.
// Digits 0-6 show the 27-bit SYS_leds value in hex, digit 7 shows SYS_output_sel
// with its decimal point lit. Both are snapshotted once per frame so the display
// never tears.
// Optional feature: define SEG_BLANK_LEADING_ZERO_EN to blank leading zero
// digits 1..6.
// Ports:
//   clk            - system clock, rising edge
//   SYS_reset      - asynchronous active-high reset
//   SYS_leds_in    - 27-bit value to display
//   SYS_output_sel - 3-bit selector shown on digit 7
//   SEG_an         - active-low digit enables, bit i = digit i
//   SEG_cat        - active-low segments {g,f,e,d,c,b,a}
//   SEG_dp         - active-low decimal point
//   frame_start    - one-cycle pulse on the first cycle of each new frame
module sys_seg_scan #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        SYS_reset,
    input  logic [26:0] SYS_leds_in,
    input  logic [2:0]  SYS_output_sel,
    output logic [7:0]  SEG_an,
    output logic [6:0]  SEG_cat,
    output logic        SEG_dp,
    output logic        frame_start
);

    localparam logic [15:0] TICK_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  digit_q, digit_d;
    logic [26:0] val_q, val_d;
    logic [2:0]  sel_q, sel_d;
    logic        frame_q, frame_d;
    logic        tick;

    always_ff @(posedge clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            cnt_q   <= '0;
            digit_q <= '0;
            val_q   <= '0;
            sel_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            val_q   <= val_d;
            sel_q   <= sel_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        tick    = (cnt_q == TICK_LAST);
        cnt_d   = cnt_q + 16'd1;
        digit_d = digit_q;
        val_d   = val_q;
        sel_d   = sel_q;
        frame_d = 1'b0;
        if (tick) begin
            cnt_d   = '0;
            digit_d = digit_q + 3'd1;
            // Snapshot on the same edge the scan wraps 7 -> 0.
            if (digit_q == 3'd7) begin
                val_d   = SYS_leds_in;
                sel_d   = SYS_output_sel;
                frame_d = 1'b1;
            end
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        g = 7'h7F;
        case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            4'hF: g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    logic [31:0] padded;
    logic [4:0]  bit_idx;
    logic [3:0]  nib;

    always_comb begin
        padded  = {5'b0, val_q};
        bit_idx = {digit_q, 2'b00};
        nib     = padded[bit_idx +: 4];
        if (digit_q == 3'd7) begin
            nib = {1'b0, sel_q};
        end
    end

`ifdef SEG_BLANK_LEADING_ZERO_EN
    logic blank;

    // Blank when this digit and all higher value digits are zero.
    always_comb begin
        blank = (digit_q != 3'd0) && (digit_q != 3'd7)
              && ((padded >> bit_idx) == 32'd0);
    end

    assign SEG_cat = blank ? 7'h7F : glyph(nib);
`else
    assign SEG_cat = glyph(nib);
`endif

    assign SEG_an      = ~(8'd1 << digit_q);
    assign SEG_dp      = (digit_q != 3'd7);
    assign frame_start = frame_q;

endmodule

// File: tb/tb_sys_seg_scan.sv
// tb_sys_seg_scan: checks three sys_seg_scan instances (SCAN_DIV 1, 2, 4)
// against a cycle-count based model plus directed literal expectations.
module tb_sys_seg_scan;

    logic        clk = 1'b0;
    logic        SYS_reset = 1'b1;
    logic [26:0] leds = 27'h1234567;
    logic [2:0]  sel = 3'd3;

    logic [7:0] an [3];
    logic [6:0] cat [3];
    logic       dp [3];
    logic       fs [3];

    int checks = 0;
    int errors = 0;

    int divs [3] = '{1, 2, 4};

    always #5 clk = ~clk;

    sys_seg_scan #(.SCAN_DIV(1)) u1 (
        .clk(clk), .SYS_reset(SYS_reset), .SYS_leds_in(leds),
        .SYS_output_sel(sel), .SEG_an(an[0]), .SEG_cat(cat[0]),
        .SEG_dp(dp[0]), .frame_start(fs[0]));
    sys_seg_scan #(.SCAN_DIV(2)) u2 (
        .clk(clk), .SYS_reset(SYS_reset), .SYS_leds_in(leds),
        .SYS_output_sel(sel), .SEG_an(an[1]), .SEG_cat(cat[1]),
        .SEG_dp(dp[1]), .frame_start(fs[1]));
    sys_seg_scan #(.SCAN_DIV(4)) u4 (
        .clk(clk), .SYS_reset(SYS_reset), .SYS_leds_in(leds),
        .SYS_output_sel(sel), .SEG_an(an[2]), .SEG_cat(cat[2]),
        .SEG_dp(dp[2]), .frame_start(fs[2]));

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] hexg(input int n);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    // Model: n = rising edges since reset release; snapshots per instance.
    int n = 0;
    int mval [3] = '{0, 0, 0};
    int msel [3] = '{0, 0, 0};

    always @(posedge clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            n <= 0;
            for (int k = 0; k < 3; k++) begin
                mval[k] <= 0;
                msel[k] <= 0;
            end
        end else begin
            n <= n + 1;
            for (int k = 0; k < 3; k++) begin
                if ((n + 1) % (8 * divs[k]) == 0) begin
                    mval[k] <= int'(leds);
                    msel[k] <= int'(sel);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int d, nb, ecat;
            d  = (n / divs[k]) % 8;
            nb = (d == 7) ? msel[k] : ((mval[k] >> (4 * d)) & 15);
            ecat = int'(hexg(nb));
`ifdef SEG_BLANK_LEADING_ZERO_EN
            if (d >= 1 && d <= 6 && (mval[k] >> (4 * d)) == 0) ecat = 'h7F;
`endif
            chk($sformatf("model_an%0d", k), 32'(an[k]),
                32'(8'hFF ^ (8'd1 << d)));
            chk($sformatf("model_cat%0d", k), 32'(cat[k]), 32'(ecat));
            chk($sformatf("model_dp%0d", k), 32'(dp[k]), 32'(d != 7));
            chk($sformatf("model_fs%0d", k), 32'(fs[k]),
                32'(n > 0 && (n % (8 * divs[k])) == 0));
        end
    end

    task automatic wait_fs(input int k, input int lim);
        int i;
        for (i = 0; i < lim; i++) begin
            @(negedge clk);
            if (fs[k]) break;
        end
        chk($sformatf("wait_fs%0d", k), 32'(i < lim), 32'd1);
    endtask

    task automatic wait_an(input int k, input logic [7:0] v, input int lim);
        int i;
        for (i = 0; i < lim; i++) begin
            @(negedge clk);
            if (an[k] == v) break;
        end
        chk($sformatf("wait_an%0d", k), 32'(i < lim), 32'd1);
    endtask

    logic [7:0] exp_an [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                               8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [6:0] exp_cat [8] = '{7'h78, 7'h02, 7'h12, 7'h19,
                                7'h30, 7'h24, 7'h79, 7'h30};
    logic [6:0] lz_cat [8];
    logic [6:0] lzv;

    initial begin
        int cnt;
`ifdef SEG_BLANK_LEADING_ZERO_EN
        lzv = 7'h7F;
`else
        lzv = 7'h40;
`endif
        lz_cat = '{7'h08, 7'h12, lzv, lzv, lzv, lzv, lzv, 7'h40};

        repeat (3) @(negedge clk);
        chk("reset_an", 32'(an[2]), 32'hFE);
        chk("reset_cat", 32'(cat[2]), 32'h40);
        chk("reset_fs", 32'(fs[2]), 32'd0);
        SYS_reset = 1'b0;

        // Value display on SCAN_DIV=1.
        wait_fs(0, 20);
        for (int i = 0; i < 8; i++) begin
            chk("val_an", 32'(an[0]), 32'(exp_an[i]));
            chk("val_cat", 32'(cat[0]), 32'(exp_cat[i]));
            chk("val_dp", 32'(dp[0]), 32'(i != 7));
            @(negedge clk);
        end

        // Leading zeros.
        leds = 27'h000005A;
        sel  = 3'd0;
        wait_fs(0, 20);
        for (int i = 0; i < 8; i++) begin
            chk("lz_cat", 32'(cat[0]), 32'(lz_cat[i]));
            @(negedge clk);
        end

        // Anti-tearing on SCAN_DIV=2.
        leds = 27'h0;
        wait_fs(1, 40);
        wait_an(1, 8'hF7, 40);
        leds = 27'h7FFFFFF;
        wait_an(1, 8'hEF, 40);
        chk("tear_d4", 32'(cat[1]), 32'(lzv));
        wait_an(1, 8'hBF, 40);
        chk("tear_d6", 32'(cat[1]), 32'(lzv));
        wait_fs(1, 40);
        chk("tear_next_d0", 32'(cat[1]), 32'h0E);
        wait_an(1, 8'hDF, 40);
        chk("tear_next_d5", 32'(cat[1]), 32'h0E);
        wait_an(1, 8'hBF, 40);
        chk("tear_next_d6", 32'(cat[1]), 32'h78);

        // Scan rate and frame spacing on SCAN_DIV=4.
        wait_fs(2, 80);
        cnt = 0;
        while (an[2] == 8'hFE && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("hold_cycles", 32'(cnt), 32'd4);
        cnt = 4;
        while (!fs[2] && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("frame_spacing", 32'(cnt), 32'd32);

        // Async reset mid-scan at digit 5.
        wait_an(2, 8'hDF, 80);
        #2 SYS_reset = 1'b1;
        #1;
        chk("areset_an", 32'(an[2]), 32'hFE);
        chk("areset_cat", 32'(cat[2]), 32'h40);
        chk("areset_dp", 32'(dp[2]), 32'd1);
        @(negedge clk);
        SYS_reset = 1'b0;
        cnt = 0;
        while (cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (fs[2]) break;
        end
        chk("reset_to_fs", 32'(cnt), 32'd32);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
